// File: rtl/sync_fifo_reader.sv
// Read-side controller for the sync FIFO: turns the one-cycle-latency read port into a
// valid/ready stream via a 2-entry skid buffer. Optional delivered-word counter: SYNC_FIFO_READER_CNT_EN.
module sync_fifo_reader #(
    parameter int unsigned FIFO_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_empty,
    input  logic [FIFO_WIDTH-1:0] iv_fifo_dout,
    output logic                  o_rd,
    output logic [FIFO_WIDTH-1:0] ov_dout,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [31:0]           ov_rd_cnt
);

    localparam int unsigned CNT_W    = 32;
    localparam int unsigned CREDIT_W = 3;

    logic [1:0]            occ;
    logic                  inflight;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [FIFO_WIDTH-1:0] skid_mem [2];
    logic                  pop;
    logic [CREDIT_W-1:0]   credit;

    // Occupancy after this cycle; reading is allowed only while a slot stays free for the reply.
    always_comb begin
        pop    = o_valid & i_ready;
        credit = CREDIT_W'({1'b0, occ}) + CREDIT_W'(inflight) - CREDIT_W'(pop);
        o_rd   = !reset & !i_empty & (credit < CREDIT_W'(2));
    end

    assign o_valid = (occ != 2'd0);
    assign ov_dout = skid_mem[rd_ptr];

    // Skid buffer: capture read data one cycle after the strobe, release in order on pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ         <= 2'd0;
            inflight    <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            skid_mem[0] <= '0;
            skid_mem[1] <= '0;
        end else begin
            inflight <= o_rd;
            if (inflight) begin
                skid_mem[wr_ptr] <= iv_fifo_dout;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= 2'(credit);
        end
    end

`ifdef SYNC_FIFO_READER_CNT_EN
    logic [CNT_W-1:0] rd_cnt;

    // Free-running delivered-word count, wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt <= '0;
        end else if (pop) begin
            rd_cnt <= rd_cnt + CNT_W'(1);
        end
    end

    assign ov_rd_cnt = rd_cnt;
`else
    assign ov_rd_cnt = '0;
`endif

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Bench for sync_fifo_reader: behavioural FIFO model plus an in-order scoreboard of written words.
module tb_sync_fifo_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_empty;
    logic [7:0]  iv_fifo_dout;
    logic        o_rd;
    logic [7:0]  ov_dout;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] ov_rd_cnt;

    int vectors;
    int miscompares;
    int rd_pulses;
    int transfers;
    int written;
    int budget;

    logic [7:0] fifo_q [$];
    logic [7:0] exp_q  [$];

    logic        s_rd;
    logic        s_valid;
    logic        s_pop;
    logic [7:0]  s_dout;
    logic [31:0] s_cnt;
    logic [31:0] exp_cnt;

    sync_fifo_reader #(.FIFO_WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_empty      (i_empty),
        .iv_fifo_dout (iv_fifo_dout),
        .o_rd         (o_rd),
        .ov_dout      (ov_dout),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .ov_rd_cnt    (ov_rd_cnt)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A write that landed on the last clock edge.
    task automatic push_word(input logic [7:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        i_empty = 1'b0;
    endtask

    // One clock: sample mid-cycle, score transfers, then advance the FIFO model past the edge.
    task automatic tick();
        @(negedge clk);
        #1;
        s_rd    = o_rd;
        s_valid = o_valid;
        s_pop   = o_valid & i_ready;
        s_dout  = ov_dout;
        s_cnt   = ov_rd_cnt;
        if (s_rd) begin
            rd_pulses++;
            check("rd_while_empty", 32'(i_empty), 32'd0);
        end
        if (s_pop) begin
            transfers++;
            if (exp_q.size() == 0) check("unexpected_word", 32'd1, 32'd0);
            else check("stream_data", 32'(s_dout), 32'(exp_q.pop_front()));
        end
        @(posedge clk);
        #1;
        if (s_rd && fifo_q.size() > 0) iv_fifo_dout = fifo_q.pop_front();
        i_empty = (fifo_q.size() == 0);
    endtask

    initial begin
        vectors = 0; miscompares = 0; rd_pulses = 0; transfers = 0; written = 0;
        reset = 1'b1; i_empty = 1'b1; i_ready = 1'b0; iv_fifo_dout = 8'h00;
        tick();
        tick();
        reset = 1'b0;

        // Idle with empty FIFO
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_rd", 32'(s_rd), 32'd0);
            check("idle_valid", 32'(s_valid), 32'd0);
            check("idle_dout", 32'(s_dout), 32'd0);
        end

        // 16 words streamed at full rate
        i_ready = 1'b1;
        for (int i = 0; i < 16; i++) push_word(8'(i));
        tick();
        check("first_rd", 32'(s_rd), 32'd1);
        check("first_valid_n", 32'(s_valid), 32'd0);
        tick();
        check("first_valid_n1", 32'(s_valid), 32'd0);
        for (int i = 0; i < 16; i++) begin
            tick();
            check("burst_gapless", 32'(s_valid), 32'd1);
        end
        tick();
        check("burst_done_valid", 32'(s_valid), 32'd0);
        check("burst_left", 32'(exp_q.size()), 32'd0);
`ifdef SYNC_FIFO_READER_CNT_EN
        exp_cnt = 32'd16;
`else
        exp_cnt = 32'd0;
`endif
        check("burst_cnt", s_cnt, exp_cnt);

        // Back-pressure: only two reads outstanding, head word held
        i_ready = 1'b0;
        rd_pulses = 0;
        for (int i = 0; i < 8; i++) push_word(8'(i));
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i >= 2) begin
                check("bp_valid", 32'(s_valid), 32'd1);
                check("bp_hold", 32'(s_dout), 32'd0);
            end
        end
        check("bp_rd_pulses", 32'(rd_pulses), 32'd2);
        i_ready = 1'b1;
        tick();
        check("bp_release_rd", 32'(s_rd), 32'd1);
        for (int i = 1; i < 8; i++) begin
            tick();
            check("bp_stream", 32'(s_valid), 32'd1);
        end
        check("bp_left", 32'(exp_q.size()), 32'd0);

        // Random writes and random ready over 1000 words
        budget = 0;
        while ((written < 1000 || exp_q.size() != 0) && budget < 20000) begin
            i_ready = 1'($urandom_range(0, 1));
            if (written < 1000 && $urandom_range(0, 1) == 1) begin
                push_word(8'($urandom));
                written++;
            end
            tick();
            budget++;
        end
        check("random_drained", 32'(exp_q.size()), 32'd0);
        check("random_written", 32'(written), 32'd1000);

        // Reset with words buffered and in flight
        for (int i = 0; i < 4; i++) tick();
        i_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(8'(8'h50 + 8'(i)));
        tick();
        tick();
        reset = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        i_empty = 1'b1;
        iv_fifo_dout = 8'h00;
        tick();
        check("rst_rd", 32'(s_rd), 32'd0);
        reset = 1'b0;
        tick();
        check("rst_valid", 32'(s_valid), 32'd0);
        check("rst_dout", 32'(s_dout), 32'd0);
        check("rst_cnt", s_cnt, 32'd0);
        transfers = 0;
        i_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_word(8'(8'hA0 + 8'(i)));
        for (int i = 0; i < 8; i++) tick();
        check("post_rst_transfers", 32'(transfers), 32'd4);
        check("post_rst_left", 32'(exp_q.size()), 32'd0);

`ifdef SYNC_FIFO_READER_CNT_EN
        // Counter wrap
        i_ready = 1'b0;
        force dut.rd_cnt = 32'hFFFF_FFFE;
        tick();
        release dut.rd_cnt;
        i_ready = 1'b1;
        for (int i = 0; i < 3; i++) push_word(8'(8'hC0 + 8'(i)));
        for (int i = 0; i < 7; i++) tick();
        check("cnt_wrap", s_cnt, 32'h0000_0001);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
